// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size codes, FSM state type, lane masks and helpers
// for the load/store front-end (mem_access_unit) and its lane merger.
// No ports; imported by byte_lane_merge and mem_access_unit.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_ILL  = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00ff;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_ffff;

    typedef enum logic {IDLE, RMW_WR} mau_state_e;

    // Big-endian lanes: byte lane n sits (3-n)*8 bits up, half lane n sits (1-n)*16 bits up.
    function automatic logic [4:0] lane_shift(input logic [1:0] addr, input logic [1:0] size);
        return (size == SIZE_BYTE) ? {~addr, 3'b000} : {~addr[1], 4'b0000};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] size);
        return (size == SIZE_ILL) | ((size == SIZE_HALF) & addr[0]) |
               ((size == SIZE_WORD) & (addr != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: bundle of the datapath-side and data_memory-side signals of
// mem_access_unit.
//   datapath : addr_in, writedata_in, re_in, we_in, size_in, signed_in ->
//              readdata_out, stall_out, misalign_out
//   memory   : mem_addr_out, mem_writedata_out, mem_re_out, mem_we_out,
//              mem_size_out -> ; mem_readdata_in <-
// Modports: slave = the unit itself, master = datapath plus memory around it.
interface mem_access_if;
    logic [31:0] addr_in;
    logic [31:0] writedata_in;
    logic        re_in;
    logic        we_in;
    logic [1:0]  size_in;
    logic        signed_in;
    logic [31:0] readdata_out;
    logic        stall_out;
    logic        misalign_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_writedata_out;
    logic        mem_re_out;
    logic        mem_we_out;
    logic [1:0]  mem_size_out;
    logic [31:0] mem_readdata_in;

    modport slave (
        input  addr_in, writedata_in, re_in, we_in, size_in, signed_in, mem_readdata_in,
        output readdata_out, stall_out, misalign_out,
               mem_addr_out, mem_writedata_out, mem_re_out, mem_we_out, mem_size_out
    );

    modport master (
        output addr_in, writedata_in, re_in, we_in, size_in, signed_in, mem_readdata_in,
        input  readdata_out, stall_out, misalign_out,
               mem_addr_out, mem_writedata_out, mem_re_out, mem_we_out, mem_size_out
    );
endinterface

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: combinational big-endian lane logic.
//   word_i   : word read from memory
//   data_i   : store data, sub-word right-justified
//   addr_i   : byte offset within the word
//   size_i   : access size code
//   signed_i : sign-extend sub-word loads
//   load_o   : extended load value
//   merge_o  : word_i with the addressed lane(s) replaced by data_i
module byte_lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [4:0]  sh;
    logic [31:0] lane_mask;
    logic [31:0] shifted;
    logic        sign_bit;

    always_comb begin
        sh        = lane_shift(addr_i, size_i);
        lane_mask = (size_i == SIZE_BYTE) ? LANE_MASK_BYTE : LANE_MASK_HALF;
        shifted   = word_i >> sh;
        sign_bit  = signed_i & ((size_i == SIZE_BYTE) ? shifted[7] : shifted[15]);
        load_o    = (size_i == SIZE_WORD) ? word_i :
                    (shifted & lane_mask) | ({32{sign_bit}} & ~lane_mask);
        merge_o   = (size_i == SIZE_WORD) ? data_i :
                    (word_i & ~(lane_mask << sh)) | ((data_i & lane_mask) << sh);
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end between the datapath and a word-only
// data_memory. Sub-word loads are extracted and extended in the same cycle;
// sub-word stores become a read cycle (stall) followed by a write of the merged word.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : mem_access_if.slave (datapath request/response + memory port)
// Optional MAU_STATS_EN adds parameter STAT_W and saturating outputs
//   rmw_count_out (RMW sequences started) and misalign_count_out (suppressed cycles).
module mem_access_unit
    import mem_access_pkg::*;
`ifdef MAU_STATS_EN
#(
    parameter int STAT_W = 16
)
`endif
(
    input  logic               clock,
    input  logic               reset,
    mem_access_if.slave        bus
`ifdef MAU_STATS_EN
    ,
    output logic [STAT_W-1:0]  rmw_count_out,
    output logic [STAT_W-1:0]  misalign_count_out
`endif
);
    mau_state_e  state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] load_word, merged_word;
    logic        misalign, live, rmw_start, load_go;

    byte_lane_merge u_lane (
        .word_i   (bus.mem_readdata_in),
        .data_i   (bus.writedata_in),
        .addr_i   (bus.addr_in[1:0]),
        .size_i   (bus.size_in),
        .signed_i (bus.signed_in),
        .load_o   (load_word),
        .merge_o  (merged_word)
    );

    // Outputs are held quiet while reset is low so an interrupted RMW never writes.
    always_comb begin
        misalign  = (bus.re_in | bus.we_in) & is_misaligned(bus.addr_in[1:0], bus.size_in);
        live      = reset & (state_q == IDLE) & ~misalign;
        rmw_start = live & bus.we_in & (bus.size_in != SIZE_WORD);
        load_go   = live & bus.re_in & ~bus.we_in;
        merge_d   = rmw_start ? merged_word : merge_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

    always_comb begin
        state_d = (state_q == RMW_WR) ? IDLE : (rmw_start ? RMW_WR : IDLE);
    end

    always_comb begin
        bus.mem_addr_out      = {bus.addr_in[31:2], 2'b00};
        bus.mem_size_out      = SIZE_WORD;
        bus.mem_writedata_out = (state_q == RMW_WR) ? merge_q : bus.writedata_in;
        bus.misalign_out      = reset & misalign;
        bus.stall_out         = rmw_start;
        bus.mem_re_out        = rmw_start | load_go;
        bus.mem_we_out        = (reset & (state_q == RMW_WR)) |
                                (live & bus.we_in & (bus.size_in == SIZE_WORD));
        bus.readdata_out      = load_go ? load_word : 32'h0;
    end

`ifdef MAU_STATS_EN
    logic [STAT_W-1:0] rmw_cnt_q, mis_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rmw_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (rmw_start && !(&rmw_cnt_q)) rmw_cnt_q <= rmw_cnt_q + STAT_W'(1);
            if (misalign && !(&mis_cnt_q)) mis_cnt_q <= mis_cnt_q + STAT_W'(1);
        end
    end

    assign rmw_count_out      = rmw_cnt_q;
    assign misalign_count_out = mis_cnt_q;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against
// a lane-level reference model and a shadow copy of a 64-word data memory.
module tb_mem_access_unit;
    logic clock;
    logic reset;

    mem_access_if tif();

`ifdef MAU_STATS_EN
    logic [15:0] rmw_count_out, misalign_count_out;
`endif

    mem_access_unit dut (
        .clock              (clock),
        .reset              (reset),
        .bus                (tif.slave)
`ifdef MAU_STATS_EN
        ,
        .rmw_count_out      (rmw_count_out),
        .misalign_count_out (misalign_count_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: asynchronous read, write on rising edge, word index = addr[7:2].
    logic [31:0] mem [64];
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [31:0] ld_val;

    assign tif.mem_readdata_in = mem[tif.mem_addr_out[7:2]];

    always @(posedge clock) begin
        if (tif.mem_we_out) mem[tif.mem_addr_out[7:2]] <= tif.mem_writedata_out;
        else if (ld_en) mem[ld_idx] <= ld_val;
    end

    // Reference state
    logic [31:0] ref_mem [64];
    int          m_rmw = 0;
    int          m_mis = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic        e_stall = 0, e_mis = 0, e_re = 0, e_we = 0;
    logic [31:0] e_rd = 0, e_wd = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
        logic [7:0]  b [4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = w[31 - 8*i -: 8];
        if (sz == 2'b00) return (sg && b[a[1:0]][7]) ? {24'hffffff, b[a[1:0]]} : {24'h0, b[a[1:0]]};
        if (sz == 2'b01) begin
            h = {b[{a[1], 1'b0}], b[{a[1], 1'b1}]};
            return (sg && h[15]) ? {16'hffff, h} : {16'h0, h};
        end
        return w;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] d,
                                            input logic [31:0] a, input logic [1:0] sz);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = w[31 - 8*i -: 8];
        if (sz == 2'b00) b[a[1:0]] = d[7:0];
        else if (sz == 2'b01) begin
            b[{a[1], 1'b0}] = d[15:8];
            b[{a[1], 1'b1}] = d[7:0];
        end else return d;
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // Compare process: every falling edge
    logic        prev_stall = 0;
    logic [68:0] held_in = '0;

    always @(negedge clock) begin
        chk("stall", 72'(tif.stall_out), 72'(e_stall));
        chk("misalign", 72'(tif.misalign_out), 72'(e_mis));
        chk("mem_re", 72'(tif.mem_re_out), 72'(e_re));
        chk("mem_we", 72'(tif.mem_we_out), 72'(e_we));
        chk("readdata", 72'(tif.readdata_out), 72'(e_rd));
        chk("mem_size", 72'(tif.mem_size_out), 72'(2'b11));
        chk("mem_addr", 72'(tif.mem_addr_out), 72'({tif.addr_in[31:2], 2'b00}));
        if (e_we) chk("mem_wdata", 72'(tif.mem_writedata_out), 72'(e_wd));
        if (prev_stall)
            chk("stable_inputs", 72'({tif.addr_in, tif.writedata_in, tif.re_in, tif.we_in,
                                      tif.size_in, tif.signed_in}), 72'(held_in));
        prev_stall = tif.stall_out;
        held_in = {tif.addr_in, tif.writedata_in, tif.re_in, tif.we_in, tif.size_in, tif.signed_in};
`ifdef MAU_STATS_EN
        chk("rmw_count", 72'(rmw_count_out), 72'(m_rmw));
        chk("misalign_count", 72'(misalign_count_out), 72'(m_mis));
`endif
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_exp(input logic st, input logic mi, input logic r, input logic w,
                           input logic [31:0] rd, input logic [31:0] wd);
        e_stall = st; e_mis = mi; e_re = r; e_we = w; e_rd = rd; e_wd = wd;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic r,
                         input logic w, input logic [1:0] sz, input logic sg);
        tif.addr_in = a; tif.writedata_in = wd; tif.re_in = r; tif.we_in = w;
        tif.size_in = sz; tif.signed_in = sg;
    endtask

    task automatic preload(input int i, input logic [31:0] v);
        drive(32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0);
        set_exp(0, 0, 0, 0, 32'h0, 32'h0);
        ld_en = 1'b1; ld_idx = 6'(i); ld_val = v; ref_mem[i] = v;
        step();
        ld_en = 1'b0;
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic r,
                       input logic w, input logic [1:0] sz, input logic sg);
        logic        mis;
        logic [31:0] nw;
        int          i;
        drive(a, wd, r, w, sz, sg);
        i = int'(a[7:2]);
        mis = (r | w) && (sz == 2'b10 || (sz == 2'b01 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00));
        if (mis) begin
            set_exp(0, 1, 0, 0, 32'h0, 32'h0);
            step();
            m_mis++;
        end else if (w && sz != 2'b11) begin
            nw = m_merge(ref_mem[i], wd, a, sz);
            set_exp(1, 0, 1, 0, 32'h0, 32'h0);
            step();
            m_rmw++;
            set_exp(0, 0, 0, 1, 32'h0, nw);
            step();
            ref_mem[i] = nw;
        end else if (w) begin
            set_exp(0, 0, 0, 1, 32'h0, wd);
            step();
            ref_mem[i] = wd;
        end else if (r) begin
            set_exp(0, 0, 1, 0, m_load(ref_mem[i], a, sz, sg), 32'h0);
            step();
        end else begin
            set_exp(0, 0, 0, 0, 32'h0, 32'h0);
            step();
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          op;
        reset = 1'b0;
        ld_en = 1'b0; ld_idx = '0; ld_val = '0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0);
        set_exp(0, 0, 0, 0, 32'h0, 32'h0);

        // Model pins
        chk("model_lb", 72'(m_load(32'h11223344, 32'h10000007, 2'b00, 1'b1)), 72'(32'h00000044));
        chk("model_lb_neg", 72'(m_load(32'h80223344, 32'h10000004, 2'b00, 1'b1)), 72'(32'hffffff80));
        chk("model_lhu", 72'(m_load(32'haaaabbcc, 32'h10000006, 2'b01, 1'b0)), 72'(32'h0000bbcc));
        chk("model_sb", 72'(m_merge(32'h11223344, 32'h000000ee, 32'h10000005, 2'b00)), 72'(32'h11ee3344));

        // Preload under reset (outputs must stay quiet)
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        reset = 1'b1;
        preload(1, 32'h11223344);

        // Loads
        txn(32'h10000004, 32'h0, 1, 0, 2'b11, 0);
        chk("lw_value", 72'(tif.readdata_out), 72'(32'h11223344));
        txn(32'h10000007, 32'h0, 1, 0, 2'b00, 1);
        preload(1, 32'h80223344);
        txn(32'h10000004, 32'h0, 1, 0, 2'b00, 1);
        preload(1, 32'haaaabbcc);
        txn(32'h10000006, 32'h0, 1, 0, 2'b01, 0);
        txn(32'h10000004, 32'h0, 1, 0, 2'b01, 1);

        // Sub-word store RMW and read-back
        preload(1, 32'h11223344);
        txn(32'h10000005, 32'h123456ee, 0, 1, 2'b00, 0);
        chk("sb_mem", 72'(mem[1]), 72'(32'h11ee3344));
        txn(32'h10000004, 32'h0, 1, 0, 2'b11, 0);

        // Misaligned / illegal
        txn(32'h10000001, 32'hdead, 0, 1, 2'b01, 0);
        txn(32'h10000002, 32'h0, 1, 0, 2'b11, 0);
        txn(32'h10000004, 32'h0, 1, 0, 2'b10, 0);
        chk("misalign_mem", 72'(mem[0]), 72'(ref_mem[0]));

        // Reset while in RMW_WR
        preload(0, 32'hcafef00d);
        drive(32'h7ffff000, 32'h0000beef, 1'b0, 1'b1, 2'b01, 1'b0);
        set_exp(1, 0, 1, 0, 32'h0, 32'h0);
        step();
        m_rmw++;
        reset = 1'b0;
        m_rmw = 0; m_mis = 0;
        set_exp(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0);
        reset = 1'b1;
        step();
        chk("rst_rmw_mem", 72'(mem[0]), 72'(32'hcafef00d));
        txn(32'h7ffff000, 32'h0, 1, 0, 2'b11, 0);

        // Statistics: three byte stores and two misaligned accesses since reset
        txn(32'h10000010, 32'h11, 0, 1, 2'b00, 0);
        txn(32'h10000013, 32'h22, 0, 1, 2'b00, 0);
        txn(32'h10000003, 32'h0, 1, 0, 2'b01, 0);
        txn(32'h10000022, 32'h33, 0, 1, 2'b00, 0);
        txn(32'h10000001, 32'h0, 0, 1, 2'b11, 0);
`ifdef MAU_STATS_EN
        chk("stat_rmw_lit", 72'(rmw_count_out), 72'(3));
        chk("stat_mis_lit", 72'(misalign_count_out), 72'(2));
`endif

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            a  = 32'h10000000 | 32'($urandom_range(0, 255));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                a[1:0] = (sz == 2'b11) ? 2'b00 : (sz == 2'b01) ? {a[1], 1'b0} : a[1:0];
            op = int'($urandom_range(0, 9));
            txn(a, $urandom, (op >= 1 && op <= 5), (op == 1 || op >= 6), sz, 1'($urandom_range(0, 1)));
        end
        txn(32'h0, 32'h0, 0, 0, 2'b11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
